// File: rtl/sad_disparity_search.sv
// rtl/sad_disparity_search.sv - streaming stereo block matcher: per-pixel SAD search over all disparities
// Windows slide on each accepted pixel; the FSM then scans one disparity candidate per cycle.
module sad_disparity_search #(
   parameter  int IMG_W    = 640,
   parameter  int IMG_H    = 480,
   parameter  int WIN      = 5,
   parameter  int MAX_DISP = 64,
   parameter  int PIX_W    = 8,
   localparam int DISP_W   = $clog2(MAX_DISP),
   localparam int COST_W   = $clog2(WIN*WIN*(2**PIX_W-1)+1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PIX_W-1:0]  in_left,
   input  logic [PIX_W-1:0]  in_right,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DISP_W-1:0] out_disp,
   output logic [COST_W-1:0] out_cost,
   output logic              out_border,
   output logic              out_eol,
   output logic              out_eof,
   output logic              out_valid,
   input  logic              out_ready
);
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int RW_W  = WIN + MAX_DISP - 1;
   localparam int RW_IW = $clog2(RW_W);
   localparam int LB_W  = (WIN - 1) * PIX_W;

   typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_HOLD} state_t;
   state_t r_state, w_state_nxt;

   logic              r_started;
   logic [COL_W-1:0]  r_col;
   logic [ROW_W-1:0]  r_row;
   logic [DISP_W-1:0] r_d, r_d_last, r_best_disp, r_disp;
   logic [COST_W-1:0] r_best_cost, r_cost;
   logic              r_border_px, r_border, r_eol, r_eof;

   logic [LB_W-1:0]   r_lb_l [IMG_W];
   logic [LB_W-1:0]   r_lb_r [IMG_W];
   logic [PIX_W-1:0]  r_win_l [WIN][WIN];
   logic [PIX_W-1:0]  r_win_r [WIN][RW_W];
   logic [PIX_W-1:0]  w_win_l_nxt [WIN][WIN];
   logic [PIX_W-1:0]  w_win_r_nxt [WIN][RW_W];

   logic              w_accept, w_is_border, w_last_col, w_last_row, w_take;
   logic [LB_W-1:0]   w_lb_l_rd, w_lb_r_rd;
   logic [COST_W-1:0] w_sad, w_cand_cost;
   logic [DISP_W-1:0] w_cand_disp, w_d_last;
   logic [RW_IW-1:0]  w_ridx;
   int                w_span;

   function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   assign in_ready    = r_started && (r_state == S_IDLE);
   assign w_accept    = in_valid && in_ready;
   assign w_is_border = (r_row < ROW_W'(WIN-1)) || (r_col < COL_W'(WIN-1));
   assign w_last_col  = (r_col == COL_W'(IMG_W-1));
   assign w_last_row  = (r_row == ROW_W'(IMG_H-1));
   assign w_lb_l_rd   = r_lb_l[r_col];
   assign w_lb_r_rd   = r_lb_r[r_col];

   // Largest disparity whose right window still lies inside the current line.
   assign w_span   = int'(r_col) - (WIN - 1);
   assign w_d_last = (w_span >= MAX_DISP - 1) ? DISP_W'(MAX_DISP - 1) : DISP_W'(w_span);

   always_comb begin
      w_win_l_nxt = r_win_l;
      w_win_r_nxt = r_win_r;
      for (int r = 0; r < WIN; r++) begin
         for (int c = WIN - 1; c > 0; c--) w_win_l_nxt[r][c] = r_win_l[r][c-1];
         for (int c = RW_W - 1; c > 0; c--) w_win_r_nxt[r][c] = r_win_r[r][c-1];
      end
      w_win_l_nxt[0][0] = in_left;
      w_win_r_nxt[0][0] = in_right;
      for (int r = 1; r < WIN; r++) begin
         w_win_l_nxt[r][0] = w_lb_l_rd[(r-1)*PIX_W +: PIX_W];
         w_win_r_nxt[r][0] = w_lb_r_rd[(r-1)*PIX_W +: PIX_W];
      end
   end

   always_comb begin
      w_sad  = '0;
      w_ridx = '0;
      for (int r = 0; r < WIN; r++) begin
         for (int c = 0; c < WIN; c++) begin
            w_ridx = RW_IW'(c) + RW_IW'(r_d);
            w_sad  = w_sad + COST_W'(abs_diff(r_win_l[r][c], r_win_r[r][w_ridx]));
         end
      end
   end

   // Strict compare keeps the smallest disparity on ties.
   assign w_take      = (r_d == '0) || (w_sad < r_best_cost);
   assign w_cand_cost = w_take ? w_sad : r_best_cost;
   assign w_cand_disp = w_take ? r_d : r_best_disp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE:   if (w_accept) w_state_nxt = S_SEARCH;
         S_SEARCH: if (r_d == r_d_last) w_state_nxt = S_HOLD;
         S_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Border pixels take a single pass through SEARCH so every result has at least one cycle latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_started   <= 1'b0;
         r_col       <= '0;
         r_row       <= '0;
         r_d         <= '0;
         r_d_last    <= '0;
         r_best_disp <= '0;
         r_best_cost <= '0;
         r_border_px <= 1'b0;
         r_disp      <= '0;
         r_cost      <= '0;
         r_border    <= 1'b0;
         r_eol       <= 1'b0;
         r_eof       <= 1'b0;
      end else begin
         r_started <= 1'b1;
         if (r_state == S_IDLE && w_accept) begin
            r_d         <= '0;
            r_border_px <= w_is_border;
            r_d_last    <= w_is_border ? '0 : w_d_last;
            r_eol       <= w_last_col;
            r_eof       <= w_last_col && w_last_row;
            if (w_last_col) begin
               r_col <= '0;
               r_row <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end else if (r_state == S_SEARCH) begin
            r_best_cost <= w_cand_cost;
            r_best_disp <= w_cand_disp;
            r_d         <= r_d + 1'b1;
            if (r_d == r_d_last) begin
               r_border <= r_border_px;
               r_disp   <= r_border_px ? '0 : w_cand_disp;
               r_cost   <= r_border_px ? '0 : w_cand_cost;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_lb_l[r_col] <= {w_lb_l_rd[LB_W-PIX_W-1:0], in_left};
         r_lb_r[r_col] <= {w_lb_r_rd[LB_W-PIX_W-1:0], in_right};
         r_win_l       <= w_win_l_nxt;
         r_win_r       <= w_win_r_nxt;
      end
   end

   assign out_disp   = r_disp;
   assign out_cost   = r_cost;
   assign out_border = r_border;
   assign out_eol    = r_eol;
   assign out_eof    = r_eof;
endmodule
